// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle ARM-subset control unit.
// Optional memory-wait handshake is enabled with MC_MEM_WAIT_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } mc_state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing command field, Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Commands whose carry/overflow results are meaningful
  function automatic logic is_arith_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Instruction-field inputs and datapath control outputs of mc_controller.
// MemReady exists only when MC_MEM_WAIT_EN is defined.
interface mc_if;
  import mc_pkg::*;

  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
`ifdef MC_MEM_WAIT_EN
  logic       MemReady;
`endif

  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] RegSrc;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;

  modport master (
`ifdef MC_MEM_WAIT_EN
    input  MemReady,
`endif
    input  Op, Funct, Rd, Cond, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUControl
  );

  modport slave (
`ifdef MC_MEM_WAIT_EN
    output MemReady,
`endif
    output Op, Funct, Rd, Cond, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl
  );

endinterface

// File: rtl/mc_condunit.sv
// NZCV flag register, condition evaluation and architectural write gating.
// Write enables are forced low for as long as reset is asserted.
module mc_condunit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       next_pc,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // NZ and CV are written independently so logical ops keep the old carry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else begin
      if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

  assign pc_write  = reset & (next_pc | (pcs & cond_ex));
  assign reg_write = reset & reg_w & cond_ex;
  assign mem_write = reset & mem_w & cond_ex;

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: main FSM, ALU decode and condition-gated writes.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  localparam logic [3:0] S_FETCH    = FETCH;
  localparam logic [3:0] S_DECODE   = DECODE;
  localparam logic [3:0] S_MEMADR   = MEMADR;
  localparam logic [3:0] S_MEMREAD  = MEMREAD;
  localparam logic [3:0] S_MEMWB    = MEMWB;
  localparam logic [3:0] S_MEMWRITE = MEMWRITE;
  localparam logic [3:0] S_EXECUTER = EXECUTER;
  localparam logic [3:0] S_EXECUTEI = EXECUTEI;
  localparam logic [3:0] S_ALUWB    = ALUWB;
  localparam logic [3:0] S_BRANCH   = BRANCH;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       mem_ready;

  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       ir_w;
  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       alu_op;

  logic [3:0] cmd;
  logic       cmd_known;
  logic       no_write;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       pcs;

`ifdef MC_MEM_WAIT_EN
  assign mem_ready = bus.MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign cmd      = bus.Funct[4:1];
  assign no_write = (cmd == CMD_CMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_nxt = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    ir_w       = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_w       = mem_ready;
        next_pc    = mem_ready;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = mem_ready;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB:    reg_w = ~no_write;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // Unrecognised commands fall back to ADD and never touch the flags
  always_comb begin
    alu_ctl   = ALU_ADD;
    cmd_known = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_ctl = ALU_ADD; cmd_known = 1'b1; end
      CMD_SUB: begin alu_ctl = ALU_SUB; cmd_known = 1'b1; end
      CMD_CMP: begin alu_ctl = ALU_SUB; cmd_known = 1'b1; end
      CMD_AND: begin alu_ctl = ALU_AND; cmd_known = 1'b1; end
      CMD_ORR: begin alu_ctl = ALU_ORR; cmd_known = 1'b1; end
      default: begin alu_ctl = ALU_ADD; cmd_known = 1'b0; end
    endcase
    if (!alu_op) alu_ctl = ALU_ADD;
  end

  assign flag_w = alu_op ? {bus.Funct[0] & cmd_known, bus.Funct[0] & is_arith_cmd(cmd)}
                         : 2'b00;

  assign pcs = ((bus.Rd == 4'd15) & reg_w) | branch;

  mc_condunit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .next_pc   (next_pc),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pc_write  (bus.PCWrite),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite)
  );

  assign bus.IRWrite    = reset & ir_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams scored against an instruction-level reference model.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [3:0] m_flags = 4'b0000;
  logic [3:0] log_we [8];
  logic [8:0] log_sel [8];

  mc_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction from its FETCH cycle to the next FETCH, scored per cycle
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input logic [3:0] af);
    int L;
    logic ok0, ok1, known, arith, pc_last, rw_last, mw_last;
    logic [1:0] ctl;
    logic [3:0] got, exp;
    L = 2; pc_last = 0; rw_last = 0; mw_last = 0; ctl = 2'b00;
    known = 0; arith = 0;
    ok0 = cond_ok(cond, m_flags);
    case (op)
      2'b00: begin
        L = 4;
        case (funct[4:1])
          4'b0100: begin ctl = 2'b00; known = 1; arith = 1; end
          4'b0010: begin ctl = 2'b01; known = 1; arith = 1; end
          4'b1010: begin ctl = 2'b01; known = 1; arith = 1; end
          4'b0000: begin ctl = 2'b10; known = 1; end
          4'b1100: begin ctl = 2'b11; known = 1; end
          default: ctl = 2'b00;
        endcase
        if (ok0 && funct[0] && known) m_flags[3:2] = af[3:2];
        if (ok0 && funct[0] && arith) m_flags[1:0] = af[1:0];
        ok1 = cond_ok(cond, m_flags);
        rw_last = ok1 && (funct[4:1] != 4'b1010);
        pc_last = rw_last && (rd == 4'd15);
      end
      2'b01: begin
        if (funct[0]) begin
          L = 5; rw_last = ok0; pc_last = ok0 && (rd == 4'd15);
        end else begin
          L = 4; mw_last = ok0;
        end
      end
      2'b10: begin L = 3; pc_last = ok0; end
      default: L = 2;
    endcase
    bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.Cond = cond; bus.ALUFlags = af;
`ifdef MC_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    for (int c = 0; c < L; c++) begin
      #1;
      got = {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
      exp = {c == 0, (c == 0) || (c == L-1 && pc_last), c == L-1 && rw_last, c == L-1 && mw_last};
      log_we[c]  = got;
      log_sel[c] = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL write_enables op=%b funct=%b cond=%b cycle=%0d got=%b want=%b",
                 op, funct, cond, c, got, exp);
      end
      if (c == 0) begin
        total++;
        if ({bus.RegSrc, bus.ImmSrc} !== {op == 2'b01, op == 2'b10, op}) begin
          bad++;
          $display("FAIL regsrc_immsrc op=%b got=%b want=%b", op,
                   {bus.RegSrc, bus.ImmSrc}, {op == 2'b01, op == 2'b10, op});
        end
      end
      if (op == 2'b00 && c == 2) begin
        total++;
        if (bus.ALUControl !== ctl) begin
          bad++;
          $display("FAIL alu_control funct=%b got=%b want=%b", funct, bus.ALUControl, ctl);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (dut.u_cond.flags !== m_flags) begin
      bad++;
      $display("FAIL flags op=%b funct=%b got=%b want=%b", op, funct, dut.u_cond.flags, m_flags);
    end
  endtask

  task automatic test_reset();
    bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd1; bus.Cond = 4'b1110;
    bus.ALUFlags = 4'b1111;
`ifdef MC_MEM_WAIT_EN
    bus.MemReady = 1'b1;
`endif
    reset = 1'b0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_we got=%b want=0000",
               {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite});
    end
    total++;
    if (dut.u_cond.flags !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", dut.u_cond.flags);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_add();
    logic [8:0] want [4];
    want[0] = 9'b0_01_10_10_00; want[1] = 9'b0_01_10_10_00;
    want[2] = 9'b0_00_00_00_00; want[3] = 9'b0_00_00_00_00;
    run_instr(2'b00, 6'b001000, 4'd1, 4'b1110, 4'($urandom));
    for (int c = 0; c < 4; c++) begin
      total++;
      if (log_sel[c] !== want[c]) begin
        bad++;
        $display("FAIL add_selects cycle=%0d got=%b want=%b", c, log_sel[c], want[c]);
      end
    end
  endtask

  task automatic test_ldr();
    logic [8:0] want [5];
    want[0] = 9'b0_01_10_10_00; want[1] = 9'b0_01_10_10_00;
    want[2] = 9'b0_00_01_00_00; want[3] = 9'b1_00_00_00_00;
    want[4] = 9'b0_00_00_01_00;
    run_instr(2'b01, 6'b011001, 4'd2, 4'b1110, 4'($urandom));
    for (int c = 0; c < 5; c++) begin
      total++;
      if (log_sel[c] !== want[c]) begin
        bad++;
        $display("FAIL ldr_selects cycle=%0d got=%b want=%b", c, log_sel[c], want[c]);
      end
    end
    total++;
    if (log_we[4] !== 4'b0010) begin
      bad++;
      $display("FAIL ldr_memwb_we got=%b want=0010", log_we[4]);
    end
  endtask

  task automatic test_cmp_branch();
    run_instr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b0100);
    run_instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'($urandom));
    total++;
    if (log_we[2][2] !== 1'b1) begin
      bad++;
      $display("FAIL beq_taken pcwrite got=%b want=1", log_we[2][2]);
    end
    total++;
    if (log_sel[2] !== 9'b0_00_01_10_00) begin
      bad++;
      $display("FAIL branch_selects got=%b want=000011000", log_sel[2]);
    end
    run_instr(2'b10, 6'b000000, 4'd0, 4'b0001, 4'($urandom));
    total++;
    if (log_we[2][2] !== 1'b0) begin
      bad++;
      $display("FAIL bne_not_taken pcwrite got=%b want=0", log_we[2][2]);
    end
  endtask

  task automatic test_reset_mid_write();
    run_instr(2'b00, 6'b010101, 4'd0, 4'b1110, 4'b1011);
    bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'd3; bus.Cond = 4'b1110;
    repeat (3) begin @(posedge clk); #1; end
    #1;
    total++;
    if (bus.MemWrite !== 1'b1) begin
      bad++;
      $display("FAIL memwrite_before_reset got=%b want=1", bus.MemWrite);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_we got=%b want=0000",
               {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite});
    end
    @(negedge clk) reset = 1'b1;
    m_flags = 4'b0000;
    #1;
    total++;
    if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, dut.u_cond.flags} !== 8'b1100_0000) begin
      bad++;
      $display("FAIL after_reset_fetch got=%b want=11000000",
               {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, dut.u_cond.flags});
    end
  endtask

  task automatic test_never();
    run_instr(2'b00, 6'b001001, 4'd4, 4'b1111, 4'b1111);
    total++;
    if (log_we[3] !== 4'b0000 || dut.u_cond.flags !== 4'b0000) begin
      bad++;
      $display("FAIL adds_never got_we=%b got_flags=%b want=0000/0000",
               log_we[3], dut.u_cond.flags);
    end
  endtask

  task automatic test_random();
    logic [3:0] cmds [5];
    logic [5:0] funct;
    logic [3:0] rd, cond;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;
    for (int i = 0; i < 300; i++) begin
      funct = 6'($urandom);
      if ($urandom_range(0, 3) != 0) funct[4:1] = cmds[$urandom_range(0, 4)];
      rd   = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom);
      cond = ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom);
      run_instr(2'($urandom), funct, rd, cond, 4'($urandom));
    end
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [3:0] got, exp;
    bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd1; bus.Cond = 4'b1110;
    for (int c = 0; c < 6; c++) begin
      bus.MemReady = (c >= 2);
      #1;
      got = {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
      exp = {c == 2, c == 2, c == 5, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL mem_wait cycle=%0d got=%b want=%b", c, got, exp);
      end
      @(posedge clk); #1;
    end
    bus.MemReady = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_cmp_branch();
    test_reset_mid_write();
    test_never();
    test_random();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
